// File: rtl/bdu_pkg.sv
// bdu_pkg: constants, dimension codes and feeder states shared by the feeder and the BDU consumer.
package bdu_pkg;
  localparam int B = 32;
  localparam int ID_W = 16;
  localparam int BW = $clog2(B + 1);
  typedef enum logic [1:0] {
    DIM_NONE = 2'b00,
    DIM_X    = 2'b01,
    DIM_Y    = 2'b10,
    DIM_Z    = 2'b11
  } dim_e;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT_DONE
  } feed_state_e;
endpackage

// File: rtl/bdu_stream_feeder_if.sv
// bdu_stream_feeder_if: query/reference loading, bit-serial stream, BDU feedback and retire signals.
interface bdu_stream_feeder_if;
  import bdu_pkg::*;
  logic            q_load;
  logic            q_ready;
  logic [B-1:0]    q_x;
  logic [B-1:0]    q_y;
  logic [B-1:0]    q_z;
  logic            ref_valid;
  logic            ref_ready;
  logic [B-1:0]    ref_x;
  logic [B-1:0]    ref_y;
  logic [B-1:0]    ref_z;
  logic [ID_W-1:0] ref_id;
  logic            valid;
  logic            q_bit;
  logic            r_bit;
  logic [1:0]      code;
  logic [BW-1:0]   b;
  logic            terminate;
  logic            done;
  logic            retire_valid;
  logic            retire_selected;
  logic [ID_W-1:0] retire_id;
  logic            err;
  modport master (
    output q_load, q_x, q_y, q_z, ref_valid, ref_x, ref_y, ref_z, ref_id, terminate, done,
    input  q_ready, ref_ready, valid, q_bit, r_bit, code, b,
           retire_valid, retire_selected, retire_id, err
  );
  modport slave (
    input  q_load, q_x, q_y, q_z, ref_valid, ref_x, ref_y, ref_z, ref_id, terminate, done,
    output q_ready, ref_ready, valid, q_bit, r_bit, code, b,
           retire_valid, retire_selected, retire_id, err
  );
endinterface

// File: rtl/bit_sequencer.sv
// bit_sequencer: walks x,y,z per bit position for bit indices 1..B; rests at code 00 / b 0 when idle.
module bit_sequencer
  import bdu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_start,
  input  logic          i_advance,
  output dim_e          o_code,
  output logic [BW-1:0] o_b,
  output logic          o_last_beat,
  output logic          o_shift_en
);
  dim_e          r_code;
  logic [BW-1:0] r_b;
  assign o_code      = r_code;
  assign o_b         = r_b;
  assign o_last_beat = r_code == DIM_Z && r_b == BW'(B);
  assign o_shift_en  = i_advance && r_code == DIM_Z;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_code <= DIM_NONE;
      r_b    <= '0;
    end else if (i_clear || (i_advance && o_last_beat)) begin
      r_code <= DIM_NONE;
      r_b    <= '0;
    end else if (i_start) begin
      r_code <= DIM_X;
      r_b    <= BW'(1);
    end else if (i_advance) begin
      r_code <= r_code == DIM_X ? DIM_Y : r_code == DIM_Y ? DIM_Z : DIM_X;
      r_b    <= r_code == DIM_Z ? r_b + BW'(1) : r_b;
    end
endmodule

// File: rtl/bdu_stream_feeder.sv
// bdu_stream_feeder: streams query/reference coordinates MSB-first, dimension-interleaved, to a BDU
// and retires each reference from the BDU's terminate/done feedback.
module bdu_stream_feeder
  import bdu_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  bdu_stream_feeder_if.slave bus
);
  feed_state_e     r_state;
  feed_state_e     w_next;
  logic [B-1:0]    r_qx, r_qy, r_qz;
  logic [B-1:0]    r_sqx, r_sqy, r_sqz;
  logic [B-1:0]    r_srx, r_sry, r_srz;
  logic [ID_W-1:0] r_id;
  logic            r_err;
  logic            w_idle, w_stream, w_accept, w_abort, w_advance;
  logic            w_last, w_shift, w_retire, w_sel, w_err_set;
  dim_e            w_code;
  logic [BW-1:0]   w_b;
  assign w_idle    = r_state == ST_IDLE;
  assign w_stream  = r_state == ST_STREAM;
  assign w_accept  = w_idle && !bus.q_load && bus.ref_valid;
  assign w_abort   = w_stream && bus.terminate;
  assign w_advance = w_stream && !bus.terminate;
  bit_sequencer u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_abort),
    .i_start    (w_accept),
    .i_advance  (w_advance),
    .o_code     (w_code),
    .o_b        (w_b),
    .o_last_beat(w_last),
    .o_shift_en (w_shift)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  // terminate outranks done in every state that listens for feedback
  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_sel     = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      ST_IDLE: w_next = w_accept ? ST_STREAM : ST_IDLE;
      ST_STREAM: begin
        w_retire  = bus.terminate;
        w_err_set = !bus.terminate && bus.done;
        w_next    = bus.terminate ? ST_IDLE : w_last ? ST_WAIT_DONE : ST_STREAM;
      end
      ST_WAIT_DONE: begin
        w_retire  = 1'b1;
        w_sel     = bus.done && !bus.terminate;
        w_err_set = !bus.done && !bus.terminate;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {r_qx, r_qy, r_qz}    <= '0;
      {r_sqx, r_sqy, r_sqz} <= '0;
      {r_srx, r_sry, r_srz} <= '0;
      r_id                  <= '0;
      r_err                 <= 1'b0;
    end else begin
      if (w_idle && bus.q_load) {r_qx, r_qy, r_qz} <= {bus.q_x, bus.q_y, bus.q_z};
      if (w_accept) begin
        {r_sqx, r_sqy, r_sqz} <= {r_qx, r_qy, r_qz};
        {r_srx, r_sry, r_srz} <= {bus.ref_x, bus.ref_y, bus.ref_z};
        r_id                  <= bus.ref_id;
      end else if (w_shift) begin
        r_sqx <= r_sqx << 1;
        r_sqy <= r_sqy << 1;
        r_sqz <= r_sqz << 1;
        r_srx <= r_srx << 1;
        r_sry <= r_sry << 1;
        r_srz <= r_srz << 1;
      end
      r_err <= r_err | w_err_set;
    end
  assign bus.q_ready         = w_idle;
  assign bus.ref_ready       = w_idle && !bus.q_load;
  assign bus.valid           = w_stream;
  assign bus.code            = w_code;
  assign bus.b               = w_b;
  assign bus.q_bit           = w_stream && (w_code == DIM_X ? r_sqx[B-1] : w_code == DIM_Y ? r_sqy[B-1] : r_sqz[B-1]);
  assign bus.r_bit           = w_stream && (w_code == DIM_X ? r_srx[B-1] : w_code == DIM_Y ? r_sry[B-1] : r_srz[B-1]);
  assign bus.retire_valid    = w_retire;
  assign bus.retire_selected = w_sel;
  assign bus.retire_id       = r_id;
  assign bus.err             = r_err;
endmodule

// File: tb/tb_bdu_stream_feeder.sv
// tb_bdu_stream_feeder: randomized scoreboard bench; the driver plays host and BDU, the monitor checks beats and retires.
module tb_bdu_stream_feeder;
  import bdu_pkg::*;
  localparam int NB = 3 * B;
  typedef enum int {M_DONE, M_TERM, M_BOTH, M_NONE, M_SDONE, M_RST} mode_e;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bdu_stream_feeder_if bus ();
  bdu_stream_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int n_tests = 0;
  int n_fail = 0;
  int last_wait = 0;
  logic [BW+3:0] beat_q[$];
  logic [ID_W+1:0] ret_q[$];
  logic [B-1:0] mq[3];
  logic exp_err = 1'b0;
  localparam logic [31:0] RST_VEC = 32'h0000_0003;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] out_vec();
    return {bus.valid, bus.q_bit, bus.r_bit, bus.code, bus.b, bus.retire_valid,
            bus.retire_selected, bus.retire_id, bus.err, bus.q_ready, bus.ref_ready};
  endfunction
  task automatic load_q(input logic [B-1:0] x, input logic [B-1:0] y, input logic [B-1:0] z);
    bus.q_load = 1'b1;
    {bus.q_x, bus.q_y, bus.q_z} = {x, y, z};
    tick();
    bus.q_load = 1'b0;
    mq = '{x, y, z};
  endtask
  // beat k (0-based) carries bit index k/3+1 of dimension k%3, MSB first
  task automatic expect_beats(input logic [B-1:0] x, input logic [B-1:0] y, input logic [B-1:0] z, input int n);
    logic [B-1:0] r[3];
    r = '{x, y, z};
    for (int k = 0; k < n; k++) begin
      int i = k / 3 + 1;
      int d = k % 3;
      beat_q.push_back({2'(d + 1), BW'(i), mq[d][B-i], r[d][B-i]});
    end
  endtask
  task automatic send(input logic [B-1:0] x, input logic [B-1:0] y, input logic [B-1:0] z,
                      input logic [ID_W-1:0] id, input mode_e m, input int kk);
    int w = 0;
    expect_beats(x, y, z, m == M_TERM ? kk : m == M_RST ? kk - 1 : NB);
    if (m != M_RST) ret_q.push_back({m == M_DONE || m == M_SDONE, id, exp_err | (m == M_SDONE)});
    bus.ref_valid = 1'b1;
    {bus.ref_x, bus.ref_y, bus.ref_z, bus.ref_id} = {x, y, z, id};
    #1;
    while (!bus.ref_ready && w < 200) begin
      tick();
      w++;
    end
    last_wait = w;
    chk("handshake_in_time", 64'(w < 200), 64'd1);
    tick();
    bus.ref_valid = 1'b0;
    for (int k = 1; k <= NB; k++) begin
      if (m == M_TERM && k == kk) begin
        bus.terminate = 1'b1;
        tick();
        bus.terminate = 1'b0;
        chk("term_valid_next", 64'(bus.valid), 64'd0);
        chk("term_ref_ready_next", 64'(bus.ref_ready), 64'd1);
        return;
      end
      if (m == M_RST && k == kk) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(out_vec()), 64'(RST_VEC));
        tick();
        rst_n = 1'b1;
        exp_err = 1'b0;
        mq = '{default: '0};
        chk("reset_err_cleared", 64'(bus.err), 64'd0);
        return;
      end
      bus.done = m == M_SDONE && k == kk;
      tick();
      bus.done = 1'b0;
    end
    chk("wait_ref_ready_low", 64'(bus.ref_ready), 64'd0);
    bus.done = m == M_DONE || m == M_BOTH || m == M_SDONE;
    bus.terminate = m == M_BOTH;
    tick();
    bus.done = 1'b0;
    bus.terminate = 1'b0;
    if (m == M_NONE || m == M_SDONE) exp_err = 1'b1;
    chk("idle_after_retire", 64'(bus.q_ready), 64'd1);
    chk("err_after_retire", 64'(bus.err), 64'(exp_err));
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (bus.valid) begin
        if (beat_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got code=%0d b=%0d, want no beat", bus.code, bus.b);
        end else chk("beat", 64'({bus.code, bus.b, bus.q_bit, bus.r_bit}), 64'(beat_q.pop_front()));
      end else chk("idle_gating", 64'({bus.code, bus.b, bus.q_bit, bus.r_bit}), 64'd0);
      if (bus.retire_valid) begin
        if (ret_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_retire: got id=0x%0h, want no retire", bus.retire_id);
        end else chk("retire", 64'({bus.retire_selected, bus.retire_id, bus.err}), 64'(ret_q.pop_front()));
      end
    end
  initial begin
    bus.q_load = 1'b0;
    bus.ref_valid = 1'b0;
    bus.terminate = 1'b0;
    bus.done = 1'b0;
    {bus.q_x, bus.q_y, bus.q_z, bus.ref_x, bus.ref_y, bus.ref_z, bus.ref_id} = '0;
    mq = '{default: '0};
    #12;
    chk("reset_outputs", 64'(out_vec()), 64'(RST_VEC));
    tick();
    rst_n = 1'b1;
    load_q(32'd1, 32'd2, 32'd3);
    send('0, '0, '0, 16'd5, M_DONE, 0);
    send($urandom, $urandom, $urandom, 16'h0011, M_TERM, 10);
    send($urandom, $urandom, $urandom, 16'h0022, M_BOTH, 0);
    bus.q_load = 1'b1;
    {bus.q_x, bus.q_y, bus.q_z} = {32'hF000_000F, 32'h8000_0001, 32'h5555_AAAA};
    bus.ref_valid = 1'b1;
    {bus.ref_x, bus.ref_y, bus.ref_z, bus.ref_id} = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0, 16'h0033};
    #1;
    chk("ref_ready_gated_by_q_load", 64'(bus.ref_ready), 64'd0);
    chk("q_ready_idle", 64'(bus.q_ready), 64'd1);
    tick();
    bus.q_load = 1'b0;
    mq = '{32'hF000_000F, 32'h8000_0001, 32'h5555_AAAA};
    send(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_F0F0, 16'h0033, M_DONE, 0);
    chk("ref_accepted_next_cycle", 64'(last_wait), 64'd0);
    bus.terminate = 1'b1;
    bus.done = 1'b1;
    repeat (3) tick();
    bus.terminate = 1'b0;
    bus.done = 1'b0;
    chk("idle_feedback_ignored", 64'({bus.q_ready, bus.err}), 64'b10);
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) load_q($urandom, $urandom, $urandom);
      send($urandom, $urandom, $urandom, 16'($urandom), mode_e'($urandom_range(0, 2)), $urandom_range(1, NB));
    end
    send($urandom, $urandom, $urandom, 16'h0044, M_NONE, 0);
    send($urandom, $urandom, $urandom, 16'h0055, M_DONE, 0);
    send($urandom, $urandom, $urandom, 16'h0066, M_RST, 40);
    send($urandom, $urandom, $urandom, 16'h0077, M_DONE, 0);
    load_q($urandom, $urandom, $urandom);
    send($urandom, $urandom, $urandom, 16'h0088, M_SDONE, 20);
    repeat (3) tick();
    chk("beat_queue_drained", 64'(beat_q.size()), 64'd0);
    chk("retire_queue_drained", 64'(ret_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bdu_stream_feeder.md
# bdu_stream_feeder

Bit-serial transmitter that drives a bit-decomposition distance unit (BDU). It latches one query point and accepts reference points over a valid/ready handshake. For each reference it emits the query and reference coordinates as MSB-first, dimension-interleaved bit pairs (x, y, z per bit position), together with the dimension code and bit index. It then consumes the BDU's `terminate`/`done` feedback and retires each reference with its outcome and ID.

## Interface
- `B`, 32: bits per coordinate dimension.
- `ID_W`, 16: reference-point identifier width.
- `clk` in 1: clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `q_load` in 1: load query point. Accepted only when `q_ready`.
- `q_ready` out 1: high in IDLE.
- `q_x`, `q_y`, `q_z` in B each: query coordinates (unsigned).
- `ref_valid` in 1 / `ref_ready` out 1: reference handshake.
- `ref_x`, `ref_y`, `ref_z` in B each: reference coordinates.
- `ref_id` in ID_W: reference tag.
- `valid` out 1: bit pair valid to the BDU.
- `q_bit`, `r_bit` out 1 each: current query and reference bits.
- `code` out 2: dimension code; 01 = x, 10 = y, 11 = z. Drives 00 when `valid` = 0.
- `b` out $clog2(B+1): bit index; 1 = MSB, B = LSB. Drives 0 when idle.
- `terminate`, `done` in 1 each: BDU feedback (combinational at the BDU).
- `retire_valid` out 1: one-cycle pulse per retired reference.
- `retire_selected` out 1: 1 = completed (kNN candidate), 0 = early-terminated or error.
- `retire_id` out ID_W: tag of the retired reference.
- `err` out 1: sticky protocol error; cleared only by reset.

## Operation
- State machine: IDLE, STREAM, WAIT_DONE.
- **IDLE**
  - `q_ready` = `ref_ready` = 1.
  - `q_load` latches the query registers. If `q_load` and `ref_valid` are both high, the query latches first. The reference is not accepted that cycle; `ref_ready` is combinationally low while `q_load` is high.
  - On `ref_valid & ref_ready`, load the reference and a working copy of the query into shift registers. Capture `ref_id`. Set dim = x, b = 1. Go to STREAM.
- **STREAM**
  - `valid` = 1.
  - `q_bit`/`r_bit` = MSB of the current dimension's shift register. `code` = current dimension. `b` = current bit index.
  - Each cycle: advance dimension x→y→z. On z, shift all six registers left by one, reset dim to x, and increment `b`.
  - After the z bit of b = B (3·B beats), go to WAIT_DONE.
- **WAIT_DONE**
  - `valid` = 0.
  - `done` = 1: retire with selected = 1, go to IDLE.
  - Neither `done` nor `terminate`: set `err`, retire with selected = 0, go to IDLE.
- **Terminate**
  - `terminate` = 1 in STREAM or WAIT_DONE: abort. Retire with selected = 0 and go to IDLE. The beat presented that cycle is discarded; the BDU clears on terminate.
  - `terminate` has priority over `done` in the same cycle.
  - `terminate`/`done` in IDLE are ignored; the BDU terminates continuously when threshold = 0.
- `done` in STREAM is a protocol violation: set `err` and ignore it.
- Reset mid-stream: all state cleared, no retire pulse. The BDU must be reset together with the feeder.

## Timing
- Reset values:
  - `valid` = 0, `q_bit` = 0, `r_bit` = 0, `code` = 00, `b` = 0.
  - `retire_valid` = 0, `retire_selected` = 0, `retire_id` = 0, `err` = 0.
  - `q_ready` = 1, `ref_ready` = 1.
  - State IDLE; all shift and query registers 0.
- Handshake at cycle N → first beat (x, b = 1) at N+1. Last beat (z, b = B) at N+3B.
- WAIT_DONE at N+3B+1: the BDU's `done` is expected here and `retire_valid` pulses here. `ref_ready` returns at N+3B+2.
- Full-length throughput: one reference per 3B+2 cycles.
- Terminate at cycle T: `retire_valid` at T (combinational from `terminate`, registered state). IDLE at T+1.
- All outputs except `retire_valid`/`retire_selected` and the `ref_ready` gating are registered.

## Structure
- Shared package `bdu_pkg`:
  - Constant B.
  - Dimension-code enum: DIM_X = 2'b01, DIM_Y = 2'b10, DIM_Z = 2'b11.
  - Feeder state enum.
  - Width localparam for `b`. The BDU consumer uses the same package.
- Sub-module `bit_sequencer`: dimension/bit-index counter.
  - Inputs: start, advance.
  - Outputs: code, b, `last_beat`, `shift_en`.
- The top level holds the FSM, shift registers and retire logic.

## Test plan
- Reset then query (1, 2, 3), reference (0, 0, 0), id 5, B = 32. Required:
  - 96 beats, code sequence 01, 10, 11 repeating.
  - `b` runs 1..32.
  - `q_bit` = 1 only at (b = 32, x), (b = 31, y), (b = 32, z), (b = 31, z).
  - BDU model asserts `done` at cycle 97 → `retire_valid`, selected = 1, id = 5.
- `terminate` forced at beat 10 (b = 4, x) → `retire_valid` same cycle, selected = 0. `valid` = 0 next cycle; `ref_ready` = 1 next cycle.
- `terminate` and `done` together in WAIT_DONE → selected = 0, `err` stays 0.
- No feedback in WAIT_DONE → `err` = 1 sticky, selected = 0, IDLE next cycle.
- `q_load` and `ref_valid` together in IDLE → query latched, reference accepted next cycle. Streamed `q_bit`s reflect the new query.
- `rst_n` asserted asynchronously at beat 40 → all outputs at reset values immediately, no retire pulse. The next reference streams from b = 1.
